// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, ALU/mux selects.
// Opcode 000101 (bne) is recognised only when MC_BNE_EN is defined.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BEQ     = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12,
        S_BNE     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    // ALUOP_NONE is used only in IDLE so that alucontrol reads 000 there.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_NONE  = 2'b11;

    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMMSH  = 2'b11;

    localparam logic [1:0] PC_ALU      = 2'b00;
    localparam logic [1:0] PC_ALUOUT   = 2'b01;
    localparam logic [1:0] PC_JUMP     = 2'b10;

    // Per-state control word; fetch/jump/branch/decode bits are later
    // combined with mem_ready, zero and op at the outputs.
    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       fetch;
        logic       jump;
        logic       branch_eq;
        logic       branch_ne;
        logic       decode;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c       = '0;
        c.aluop = ALUOP_ADD;
        case (s)
            S_IDLE:    c.aluop = ALUOP_NONE;
            S_FETCH: begin
                c.alusrcb = ALUB_FOUR;
                c.pcsrc   = PC_ALU;
                c.fetch   = 1'b1;
            end
            S_DECODE: begin
                c.alusrcb = ALUB_IMMSH;
                c.decode  = 1'b1;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = ALUB_IMM;
            end
            S_MEMRD:   c.iord = 1'b1;
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                c.alusrca = 1'b1;
                c.alusrcb = ALUB_REG;
                c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BEQ, S_BNE: begin
                c.alusrca   = 1'b1;
                c.alusrcb   = ALUB_REG;
                c.aluop     = ALUOP_SUB;
                c.pcsrc     = PC_ALUOUT;
                c.branch_eq = (s == S_BEQ);
                c.branch_ne = (s == S_BNE);
            end
            S_ADDIWB:  c.regwrite = 1'b1;
            S_JUMP: begin
                c.pcsrc = PC_JUMP;
                c.jump  = 1'b1;
            end
            default:   c.aluop = ALUOP_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_control.sv
// ALU operation decoder: aluop selects add/sub directly or defers to the R-type funct field.
module alu_control
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    always_comb begin
        case (aluop)
            ALUOP_ADD:   alucontrol = 3'b010;
            ALUOP_SUB:   alucontrol = 3'b110;
            ALUOP_FUNCT: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b000;
                endcase
            end
            default:     alucontrol = 3'b000;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with registered per-state controls and mem_ready/zero gating.
// Define MC_BNE_EN to decode opcode 000101 (bne); otherwise it is reported as illegal.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    state_t state;
    state_t next_state;
    ctrl_t  ctl;
    logic   op_known;

    always_comb begin
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_known = 1'b1;
`ifdef MC_BNE_EN
            OP_BNE:                                        op_known = 1'b1;
`endif
            default:                                       op_known = 1'b0;
        endcase
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       next_state = S_BNE;
`endif
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWR:  if (mem_ready) next_state = S_FETCH;
            S_EXECUTE: next_state = S_ALUWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_BNE, S_JUMP: next_state = S_FETCH;
            default:   next_state = S_IDLE;
        endcase
    end

    // NOTE: state and control word are sequential, so they use non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ctl   <= state_ctrl(S_IDLE);
        end else begin
            state <= next_state;
            ctl   <= state_ctrl(next_state);
        end
    end

    alu_control u_alu_control (
        .funct      (funct),
        .aluop      (ctl.aluop),
        .alucontrol (alucontrol)
    );

    assign iord     = ctl.iord;
    assign memwrite = ctl.memwrite;
    assign regdst   = ctl.regdst;
    assign memtoreg = ctl.memtoreg;
    assign regwrite = ctl.regwrite;
    assign alusrca  = ctl.alusrca;
    assign alusrcb  = ctl.alusrcb;
    assign pcsrc    = ctl.pcsrc;

    // Fetch strobes fire only in the cycle the memory completes the read.
    assign irwrite = ctl.fetch & mem_ready;
    assign pcen    = (ctl.fetch & mem_ready) | ctl.jump
                   | (ctl.branch_eq & zero) | (ctl.branch_ne & ~zero);
    assign illegal = ctl.decode & ~op_known;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: expected output words queued per cycle, checked at negedge.
// Honours MC_BNE_EN the same way the design does.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .alucontrol (alucontrol),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Field order: iord memwrite irwrite regdst memtoreg regwrite alusrca alusrcb pcsrc pcen alucontrol illegal
    logic [15:0] outs;
    assign outs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                   alusrcb, pcsrc, pcen, alucontrol, illegal};

    localparam logic [15:0] E_IDLE     = 16'h0000;
    localparam logic [15:0] E_FETCH    = {7'b0010000, 2'b01, 2'b00, 1'b1, 3'b010, 1'b0};
    localparam logic [15:0] E_FETCHW   = {7'b0000000, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [15:0] E_DECODE   = {7'b0000000, 2'b11, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [15:0] E_DECBAD   = {7'b0000000, 2'b11, 2'b00, 1'b0, 3'b010, 1'b1};
    localparam logic [15:0] E_MEMADR   = {7'b0000001, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [15:0] E_MEMRD    = {7'b1000000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [15:0] E_MEMWB    = {7'b0000110, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [15:0] E_MEMWR    = {7'b1100000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [15:0] E_EXEADD   = {7'b0000001, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [15:0] E_EXESUB   = {7'b0000001, 2'b00, 2'b00, 1'b0, 3'b110, 1'b0};
    localparam logic [15:0] E_ALUWB    = {7'b0001010, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [15:0] E_BRTAKEN  = {7'b0000001, 2'b00, 2'b01, 1'b1, 3'b110, 1'b0};
    localparam logic [15:0] E_BRNOT    = {7'b0000001, 2'b00, 2'b01, 1'b0, 3'b110, 1'b0};
    localparam logic [15:0] E_ADDIEX   = {7'b0000001, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [15:0] E_ADDIWB   = {7'b0000010, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
    localparam logic [15:0] E_JUMP     = {7'b0000000, 2'b00, 2'b10, 1'b1, 3'b010, 1'b0};

    // Drive one cycle of inputs, queue the expected outputs, compare at the falling edge.
    task automatic step(input logic r, input logic mr, input logic z,
                        input logic [15:0] exp, input string tag);
        logic [15:0] e;
        string       t;
        rst       = r;
        mem_ready = mr;
        zero      = z;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (outs === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", t, outs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [5:0] o, input logic [5:0] f);
        op    = o;
        funct = f;
    endtask

    initial begin
        rst = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held, then released: IDLE outputs stay zero, FETCH follows
        step(1, 1, 0, E_IDLE, "rst_held");
        step(0, 1, 0, E_IDLE, "idle_after_rst");

        // lw, no wait states
        set_ir(6'b100011, 6'b0);
        step(0, 1, 0, E_FETCH,  "lw_fetch");
        step(0, 1, 0, E_DECODE, "lw_decode");
        step(0, 1, 0, E_MEMADR, "lw_memadr");
        step(0, 1, 0, E_MEMRD,  "lw_memrd");
        step(0, 1, 0, E_MEMWB,  "lw_memwb");

        // sw, memory stalls three cycles in MEMWR
        set_ir(6'b101011, 6'b0);
        step(0, 1, 0, E_FETCH,  "sw_fetch");
        step(0, 0, 0, E_DECODE, "sw_decode_mr_ignored");
        step(0, 1, 0, E_MEMADR, "sw_memadr");
        step(0, 0, 0, E_MEMWR,  "sw_memwr_wait1");
        step(0, 0, 0, E_MEMWR,  "sw_memwr_wait2");
        step(0, 0, 0, E_MEMWR,  "sw_memwr_wait3");
        step(0, 1, 0, E_MEMWR,  "sw_memwr_done");

        // beq taken, then not taken
        set_ir(6'b000100, 6'b0);
        step(0, 1, 1, E_FETCH,   "beq1_fetch");
        step(0, 1, 1, E_DECODE,  "beq1_decode");
        step(0, 1, 1, E_BRTAKEN, "beq1_taken");
        step(0, 1, 0, E_FETCH,   "beq0_fetch");
        step(0, 1, 0, E_DECODE,  "beq0_decode");
        step(0, 1, 0, E_BRNOT,   "beq0_not_taken");

        // R-type add, then R-type sub with one fetch wait state
        set_ir(6'b000000, 6'b100000);
        step(0, 1, 0, E_FETCH,  "radd_fetch");
        step(0, 1, 0, E_DECODE, "radd_decode");
        step(0, 1, 1, E_EXEADD, "radd_execute");
        step(0, 1, 0, E_ALUWB,  "radd_aluwb");
        set_ir(6'b000000, 6'b100010);
        step(0, 0, 0, E_FETCHW, "rsub_fetch_wait");
        step(0, 1, 0, E_FETCH,  "rsub_fetch");
        step(0, 1, 0, E_DECODE, "rsub_decode");
        step(0, 1, 0, E_EXESUB, "rsub_execute");
        step(0, 1, 0, E_ALUWB,  "rsub_aluwb");

        // j
        set_ir(6'b000010, 6'b0);
        step(0, 1, 0, E_FETCH,  "j_fetch");
        step(0, 1, 0, E_DECODE, "j_decode");
        step(0, 1, 0, E_JUMP,   "j_jump");

        // addi
        set_ir(6'b001000, 6'b0);
        step(0, 1, 0, E_FETCH,  "addi_fetch");
        step(0, 1, 0, E_DECODE, "addi_decode");
        step(0, 1, 0, E_ADDIEX, "addi_ex");
        step(0, 1, 0, E_ADDIWB, "addi_wb");

        // lw with two wait states in MEMRD
        set_ir(6'b100011, 6'b0);
        step(0, 1, 0, E_FETCH,  "lww_fetch");
        step(0, 1, 0, E_DECODE, "lww_decode");
        step(0, 0, 0, E_MEMADR, "lww_memadr_mr_ignored");
        step(0, 0, 0, E_MEMRD,  "lww_memrd_wait1");
        step(0, 0, 0, E_MEMRD,  "lww_memrd_wait2");
        step(0, 1, 0, E_MEMRD,  "lww_memrd_done");
        step(0, 1, 0, E_MEMWB,  "lww_memwb");

        // Opcode 000101: bne when enabled, illegal otherwise
        set_ir(6'b000101, 6'b0);
        step(0, 1, 0, E_FETCH,   "bne_fetch");
`ifdef MC_BNE_EN
        step(0, 1, 0, E_DECODE,  "bne_decode");
        step(0, 1, 0, E_BRTAKEN, "bne_taken");
`else
        step(0, 1, 0, E_DECBAD,  "bne_illegal");
`endif

        // Unknown opcode: single illegal pulse, straight back to FETCH
        set_ir(6'b111111, 6'b0);
        step(0, 1, 0, E_FETCH,  "bad_fetch");
        step(0, 1, 0, E_DECBAD, "bad_decode");
        set_ir(6'b000010, 6'b0);
        step(0, 1, 0, E_FETCH,  "bad_next_fetch");
        step(0, 1, 0, E_DECODE, "bad_next_decode");
        step(0, 1, 0, E_JUMP,   "bad_next_jump");

        // Reset while MEMRD is stalled
        set_ir(6'b100011, 6'b0);
        step(0, 1, 0, E_FETCH,  "rstw_fetch");
        step(0, 1, 0, E_DECODE, "rstw_decode");
        step(0, 1, 0, E_MEMADR, "rstw_memadr");
        step(0, 0, 0, E_MEMRD,  "rstw_memrd_wait");
        step(1, 0, 0, E_MEMRD,  "rstw_memrd_rst");
        step(0, 0, 0, E_IDLE,   "rstw_idle");
        step(0, 1, 0, E_FETCH,  "rstw_fetch_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
